// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared CPU package: fetch FSM encoding and defaults
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int ADDR_W_DEF         = 32;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read bus between fetch unit and memory
interface instr_fetch_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/instr_fetch_timer.sv
// rtl/instr_fetch_timer.sv - fetch_timer: counts unacknowledged request cycles
module fetch_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Fires during the LIMIT-th enabled cycle so the owner leaves on that edge.
  assign expired_o = enable_i && !clear_i && (count_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM with one-deep pending request and timeout fault
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int ADDR_W         = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCAddr,
  input  logic              GetInstruction,
  output logic [ADDR_W-1:0] Instruction,
  output logic              InstrValid,
  input  logic              InstrAccept,
  output logic              Busy,
  output logic              FetchFault,
  instr_fetch_if.master     mem
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic              expired;

  fetch_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != ST_REQ),
    .enable_i ((state_q == ST_REQ) && !mem.mem_ack),
    .expired_o(expired)
  );

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (GetInstruction) begin
          state_d    = ST_REQ;
          mem_addr_d = PCAddr;
          mem_req_d  = 1'b1;
        end
      end

      ST_REQ: begin
        if (GetInstruction) begin
          pend_addr_d  = PCAddr;
          pend_valid_d = 1'b1;
        end
        if (mem.mem_ack) begin
          state_d   = ST_HOLD;
          instr_d   = mem.mem_rdata;
          valid_d   = 1'b1;
          mem_req_d = 1'b0;
        end else if (expired) begin
          state_d      = ST_FAULT;
          mem_req_d    = 1'b0;
          fault_d      = 1'b1;
          pend_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (GetInstruction) begin
          pend_addr_d  = PCAddr;
          pend_valid_d = 1'b1;
        end
        if (InstrAccept) begin
          valid_d = 1'b0;
          if (pend_valid_q) begin
            // Stored request goes first; a same-cycle strobe stays pending behind it.
            state_d      = ST_REQ;
            mem_addr_d   = pend_addr_q;
            mem_req_d    = 1'b1;
            pend_valid_d = GetInstruction;
          end else if (GetInstruction) begin
            state_d      = ST_REQ;
            mem_addr_d   = PCAddr;
            mem_req_d    = 1'b1;
            pend_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_FAULT: begin
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_req  = mem_req_q;
  assign Instruction  = instr_q;
  assign InstrValid   = valid_q;
  assign Busy         = busy_q;
  assign FetchFault   = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCAddr = '0;
  logic        GetInstruction = 1'b0;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrAccept = 1'b0;
  logic        Busy;
  logic        FetchFault;

  int checks = 0;
  int failures = 0;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(
    .TIMEOUT_CYCLES(16),
    .ADDR_W        (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCAddr        (PCAddr),
    .GetInstruction(GetInstruction),
    .Instruction   (Instruction),
    .InstrValid    (InstrValid),
    .InstrAccept   (InstrAccept),
    .Busy          (Busy),
    .FetchFault    (FetchFault),
    .mem           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    // Reset state, with a strobe during reset that must be dropped
    rst = 1'b1;
    tick();
    GetInstruction = 1'b1;
    PCAddr = 32'h99;
    tick();
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_valid", {31'b0, InstrValid}, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_fault", {31'b0, FetchFault}, 32'd0);

    // First fetch immediately after reset, minimum latency
    rst = 1'b0;
    PCAddr = 32'h10;
    tick();
    chk("f1_req", {31'b0, bus.mem_req}, 32'd1);
    chk("f1_addr", bus.mem_addr, 32'h10);
    chk("f1_busy", {31'b0, Busy}, 32'd1);
    chk("f1_valid_in_req", {31'b0, InstrValid}, 32'd0);
    GetInstruction = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    chk("f1_valid", {31'b0, InstrValid}, 32'd1);
    chk("f1_instr", Instruction, 32'hDEADBEEF);
    chk("f1_req_drop", {31'b0, bus.mem_req}, 32'd0);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;

    // Hold for 5 cycles; a stray ack in HOLD is ignored
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h11111111;
      end else begin
        bus.mem_ack = 1'b0;
      end
      tick();
      chk("hold_valid", {31'b0, InstrValid}, 32'd1);
      chk("hold_instr", Instruction, 32'hDEADBEEF);
    end
    bus.mem_ack = 1'b0;
    InstrAccept = 1'b1;
    tick();
    InstrAccept = 1'b0;
    chk("acc_valid", {31'b0, InstrValid}, 32'd0);
    chk("acc_busy_idle", {31'b0, Busy}, 32'd0);
    chk("acc_req", {31'b0, bus.mem_req}, 32'd0);

    // Latest pending PC wins
    GetInstruction = 1'b1;
    PCAddr = 32'h40;
    tick();
    chk("p_addr40", bus.mem_addr, 32'h40);
    PCAddr = 32'h20;
    tick();
    chk("p_addr_stable", bus.mem_addr, 32'h40);
    chk("p_req_stable", {31'b0, bus.mem_req}, 32'd1);
    PCAddr = 32'h24;
    tick();
    GetInstruction = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hA1;
    tick();
    bus.mem_ack = 1'b0;
    chk("p_instr_a1", Instruction, 32'hA1);
    InstrAccept = 1'b1;
    tick();
    InstrAccept = 1'b0;
    chk("p_next_addr", bus.mem_addr, 32'h24);
    chk("p_next_req", {31'b0, bus.mem_req}, 32'd1);
    chk("p_next_valid", {31'b0, InstrValid}, 32'd0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hA2;
    tick();
    bus.mem_ack = 1'b0;
    chk("p_instr_a2", Instruction, 32'hA2);

    // Accept and new strobe in the same HOLD cycle: back-to-back fetch
    InstrAccept = 1'b1;
    GetInstruction = 1'b1;
    PCAddr = 32'h30;
    tick();
    InstrAccept = 1'b0;
    GetInstruction = 1'b0;
    chk("b2b_req", {31'b0, bus.mem_req}, 32'd1);
    chk("b2b_addr", bus.mem_addr, 32'h30);
    chk("b2b_busy", {31'b0, Busy}, 32'd1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hA3;
    tick();
    bus.mem_ack = 1'b0;
    chk("b2b_instr", Instruction, 32'hA3);
    InstrAccept = 1'b1;
    tick();
    InstrAccept = 1'b0;
    chk("no_stale_pend_req", {31'b0, bus.mem_req}, 32'd0);
    chk("no_stale_pend_busy", {31'b0, Busy}, 32'd0);

    // Timeout: 16 REQ cycles without ack
    GetInstruction = 1'b1;
    PCAddr = 32'h50;
    tick();
    PCAddr = 32'h60;
    tick();
    GetInstruction = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_still_req", {31'b0, bus.mem_req}, 32'd1);
    chk("to_no_fault_yet", {31'b0, FetchFault}, 32'd0);
    tick();
    chk("to_fault", {31'b0, FetchFault}, 32'd1);
    chk("to_req_low", {31'b0, bus.mem_req}, 32'd0);
    chk("to_busy", {31'b0, Busy}, 32'd1);
    GetInstruction = 1'b1;
    PCAddr = 32'h70;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_ignore_req", {31'b0, bus.mem_req}, 32'd0);
      chk("fault_sticky", {31'b0, FetchFault}, 32'd1);
      chk("fault_no_valid", {31'b0, InstrValid}, 32'd0);
    end
    GetInstruction = 1'b0;
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fault_cleared", {31'b0, FetchFault}, 32'd0);
    chk("fault_rst_busy", {31'b0, Busy}, 32'd0);

    // Reset mid-REQ, then a late ack must be ignored
    GetInstruction = 1'b1;
    PCAddr = 32'h80;
    tick();
    GetInstruction = 1'b0;
    chk("mid_req", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mid_rst_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h55;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, InstrValid}, 32'd0);
    chk("late_ack_instr", Instruction, 32'd0);
    chk("late_ack_busy", {31'b0, Busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum number of cycles mem_req may stay high without mem_ack before a fault is raised.
REQ-002 Parameter ADDR_W, default 32: address and data width.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 PCAddr  input  ADDR_W  fetch address from the program counter.
REQ-006 GetInstruction  input  1  fetch request strobe from the program counter; PCAddr is valid in the same cycle.
REQ-007 mem_addr  output  ADDR_W  instruction memory word address.
REQ-008 mem_req  output  1  memory read request; held high until mem_ack is seen.
REQ-009 mem_rdata  input  ADDR_W  memory read data; valid when mem_ack is high.
REQ-010 mem_ack  input  1  memory read completion, one cycle per request.
REQ-011 Instruction  output  ADDR_W  fetched instruction word.
REQ-012 InstrValid  output  1  Instruction holds a word not yet accepted.
REQ-013 InstrAccept  input  1  decoder takes Instruction when InstrValid and InstrAccept are both high.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 FetchFault  output  1  sticky memory-timeout flag.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, HOLD, FAULT.
REQ-017 IDLE: GetInstruction sampled high -> next cycle REQ, with mem_addr=PCAddr and mem_req=1.
REQ-018 REQ: mem_req and mem_addr SHALL stay stable until the edge that samples mem_ack=1.
REQ-019 On that edge, Instruction SHALL load mem_rdata, state SHALL go to HOLD, and InstrValid=1 from the next cycle.
REQ-020 Minimum latency: GetInstruction at edge N, mem_ack at edge N+1 -> InstrValid high in cycle N+2.
REQ-021 HOLD: Instruction and InstrValid SHALL stay stable until InstrAccept=1. Then:
- pending request stored -> REQ with the pending address;
- else GetInstruction high in the same cycle -> REQ with PCAddr;
- else -> IDLE.
REQ-022 GetInstruction in REQ or HOLD SHALL be stored in a one-deep pending register (address plus valid flag).
REQ-023 A later GetInstruction SHALL overwrite the pending address; the latest PC wins.
REQ-024 A stored pending request SHALL clear when it is issued.
REQ-025 mem_ack outside REQ SHALL be ignored.
REQ-026 A timeout counter SHALL clear on entry to REQ and count every REQ cycle without mem_ack.
REQ-027 When the counter reaches TIMEOUT_CYCLES, the block SHALL go to FAULT with mem_req=0, FetchFault=1 and the pending request discarded.
REQ-028 FAULT SHALL be exited only by rst; GetInstruction in FAULT is ignored.
REQ-029 InstrValid SHALL never be high in REQ, IDLE or FAULT.

Reset
REQ-030 rst high at a clock edge SHALL force, at any point including mid-transaction:
- state=IDLE;
- mem_req=0, mem_addr=0;
- Instruction=0, InstrValid=0;
- pending cleared, timeout counter=0;
- FetchFault=0, Busy=0.
REQ-031 GetInstruction sampled in the same cycle as rst SHALL be dropped.
REQ-032 The first request SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-033 The state encoding and the TIMEOUT_CYCLES default SHALL live in the shared CPU package.
REQ-034 The timeout counter SHALL be one sub-module, fetch_timer (inputs clear/enable, output expired).
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 After rst, GetInstruction with PCAddr=0x10 and mem_ack one cycle after mem_req (rdata 0xDEADBEEF) -> mem_addr=0x10, then InstrValid=1 with Instruction=0xDEADBEEF two cycles after the strobe.
REQ-037 Hold InstrAccept=0 for 5 cycles, then pulse it -> Instruction stays stable and InstrValid stays high for all 5 cycles; back to IDLE.
REQ-038 During REQ, GetInstruction with 0x20 and then 0x24 -> after the first word is accepted, the next mem_addr is 0x24 and 0x20 is never fetched.
REQ-039 In HOLD, InstrAccept and GetInstruction (0x30) in the same cycle -> next cycle REQ with mem_addr=0x30 and no idle gap.
REQ-040 No mem_ack for 16 REQ cycles -> FetchFault=1 and mem_req=0; further GetInstruction is ignored until rst, which clears FetchFault.
REQ-041 rst asserted during REQ -> all outputs return to reset values next cycle, and a late mem_ack is ignored.
